// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM bus arbiter: FSM state encoding,
// grant encoding and the pipeline stall request levels.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

  // Stall request levels as seen by the pipeline controller.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // The port that was not granted.
  function automatic grant_t other_port(input grant_t g);
    return (g == GNT_IF) ? GNT_MEM : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Shared SRAM-like bus: address phase (bus_req/bus_addr_ok) followed by a
// data phase (bus_data_ok/bus_rdata). master = arbiter, slave = memory.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  bus_req;
  logic                  bus_wr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the IF and MEM requesters.
// MEM_ARB_RR_EN defined: on a collision the port not granted last wins.
// MEM_ARB_RR_EN undefined: MEM always wins; no last-grant input exists.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
`ifdef MEM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output logic   req_any,
  output grant_t winner
);

  // Winner select; a lone requester always wins.
  always_comb begin
    req_any = inst_req | data_req;
`ifdef MEM_ARB_RR_EN
    if (inst_req && data_req) begin
      winner = other_port(last_grant);
    end else if (data_req) begin
      winner = GNT_MEM;
    end else begin
      winner = GNT_IF;
    end
`else
    winner = data_req ? GNT_MEM : GNT_IF;
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// IF/MEM arbiter onto one shared bus with a single outstanding transaction.
// Responses are registered back to the granted requester as a one-cycle ok.
// Build option: MEM_ARB_RR_EN selects round-robin instead of MEM priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  mem_bus_arbiter_if.master   bus,
  output logic                stallreq_for_bus
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state_reg, state_next;
  grant_t              grant_reg, grant_next;
  logic                bus_req_reg, bus_req_next;
  logic                bus_wr_reg, bus_wr_next;
  logic [STRB_W-1:0]   bus_wstrb_reg, bus_wstrb_next;
  logic [ADDR_W-1:0]   bus_addr_reg, bus_addr_next;
  logic [DATA_W-1:0]   bus_wdata_reg, bus_wdata_next;
  logic                inst_ok_reg, inst_ok_next;
  logic                data_ok_reg, data_ok_next;
  logic [DATA_W-1:0]   inst_rdata_reg, inst_rdata_next;
  logic [DATA_W-1:0]   data_rdata_reg, data_rdata_next;

  logic                pick_any;
  grant_t              pick_grant;

  // grant_reg doubles as the last-grant pointer for round-robin.
  mem_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (grant_reg),
`endif
    .req_any    (pick_any),
    .winner     (pick_grant)
  );

  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_wr    = bus_wr_reg;
  assign bus.bus_wstrb = bus_wstrb_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_wdata = bus_wdata_reg;
  assign inst_ok       = inst_ok_reg;
  assign data_ok       = data_ok_reg;
  assign inst_rdata    = inst_rdata_reg;
  assign data_rdata    = data_rdata_reg;

  // State and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= GNT_IF;
      bus_req_reg    <= 1'b0;
      bus_wr_reg     <= 1'b0;
      bus_wstrb_reg  <= '0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      inst_ok_reg    <= 1'b0;
      data_ok_reg    <= 1'b0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      bus_req_reg    <= bus_req_next;
      bus_wr_reg     <= bus_wr_next;
      bus_wstrb_reg  <= bus_wstrb_next;
      bus_addr_reg   <= bus_addr_next;
      bus_wdata_reg  <= bus_wdata_next;
      inst_ok_reg    <= inst_ok_next;
      data_ok_reg    <= data_ok_next;
      inst_rdata_reg <= inst_rdata_next;
      data_rdata_reg <= data_rdata_next;
    end
  end

  // Next-state and next-output logic; ok pulses are set only on entry to RESP.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    bus_req_next    = bus_req_reg;
    bus_wr_next     = bus_wr_reg;
    bus_wstrb_next  = bus_wstrb_reg;
    bus_addr_next   = bus_addr_reg;
    bus_wdata_next  = bus_wdata_reg;
    inst_ok_next    = 1'b0;
    data_ok_next    = 1'b0;
    inst_rdata_next = inst_rdata_reg;
    data_rdata_next = data_rdata_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          state_next   = ST_ADDR;
          grant_next   = pick_grant;
          bus_req_next = 1'b1;
          if (pick_grant == GNT_MEM) begin
            // Reads carry no strobes or write data onto the bus.
            bus_wr_next    = data_wr;
            bus_wstrb_next = data_wr ? data_wstrb : '0;
            bus_addr_next  = data_addr;
            bus_wdata_next = data_wr ? data_wdata : '0;
          end else begin
            bus_wr_next    = 1'b0;
            bus_wstrb_next = '0;
            bus_addr_next  = inst_addr;
            bus_wdata_next = '0;
          end
        end
      end

      ST_ADDR: begin
        if (bus.bus_addr_ok) begin
          bus_req_next = 1'b0;
          if (bus.bus_data_ok) begin
            // Slave finished in the address cycle: skip DATA.
            state_next = ST_RESP;
            if (grant_reg == GNT_MEM) begin
              data_ok_next    = 1'b1;
              data_rdata_next = bus.bus_rdata;
            end else begin
              inst_ok_next    = 1'b1;
              inst_rdata_next = bus.bus_rdata;
            end
          end else begin
            state_next = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (bus.bus_data_ok) begin
          state_next = ST_RESP;
          if (grant_reg == GNT_MEM) begin
            data_ok_next    = 1'b1;
            data_rdata_next = bus.bus_rdata;
          end else begin
            inst_ok_next    = 1'b1;
            inst_rdata_next = bus.bus_rdata;
          end
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Stall while a request is pending or a transaction is in flight; in RESP
  // only the other port's request keeps the pipeline frozen.
  always_comb begin
    stallreq_for_bus = NoStop;
    unique case (state_reg)
      ST_IDLE: stallreq_for_bus = (inst_req | data_req) ? Stop : NoStop;
      ST_ADDR: stallreq_for_bus = Stop;
      ST_DATA: stallreq_for_bus = Stop;
      ST_RESP: begin
        if (grant_reg == GNT_IF) begin
          stallreq_for_bus = data_req ? Stop : NoStop;
        end else begin
          stallreq_for_bus = inst_req ? Stop : NoStop;
        end
      end
      default: stallreq_for_bus = NoStop;
    endcase
  end

endmodule
